// File: rtl/pixel_stream_tx_pkg.sv
// Shared types and default timing for the pixel stream transmitter.
package pixel_stream_tx_pkg;

  // Width of every position and timing counter.
  localparam int unsigned CNT_W = 15;

  // Default timing constants.
  localparam int unsigned DEF_H_ACTIVE = 176;
  localparam int unsigned DEF_V_ACTIVE = 144;
  localparam int unsigned DEF_VS_LEN   = 8;
  localparam int unsigned DEF_V_BACK   = 4;
  localparam int unsigned DEF_H_BLANK  = 4;

  typedef logic [CNT_W-1:0] cnt_t;

  // Frame sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_VSYNC  = 3'd1,
    ST_VBACK  = 3'd2,
    ST_LINE   = 3'd3,
    ST_HBLANK = 3'd4,
    ST_END    = 3'd5
  } state_t;

endpackage

// File: rtl/pixel_stream_tx.sv
// Reads RGB565 pixels from a synchronous frame memory and emits them as a
// VSYNC/HREF byte stream, low byte first, two cycles per pixel.
module pixel_stream_tx
  import pixel_stream_tx_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned VS_LEN   = DEF_VS_LEN,
  parameter int unsigned V_BACK   = DEF_V_BACK,
  parameter int unsigned H_BLANK  = DEF_H_BLANK
) (
  input  logic        CLK,
  input  logic        RES,
  input  logic        EN,
  output logic [14:0] RD_X,
  output logic [14:0] RD_Y,
  input  logic [15:0] RD_DATA,
  output logic        VSYNC,
  output logic        HREF,
  output logic [7:0]  D,
  output logic        BUSY,
  output logic        FRAME_DONE
);

  // Terminal counts for each timed state.
  localparam cnt_t VS_LAST   = CNT_W'(VS_LEN - 1);
  localparam cnt_t VB_LAST   = CNT_W'(V_BACK - 1);
  localparam cnt_t LINE_LAST = CNT_W'(2 * H_ACTIVE - 1);
  localparam cnt_t HB_LAST   = CNT_W'(H_BLANK - 1);
  localparam cnt_t X_LAST    = CNT_W'(H_ACTIVE - 1);
  localparam cnt_t LINES     = CNT_W'(V_ACTIVE);
  localparam cnt_t LINES_M1  = CNT_W'(V_ACTIVE - 1);

  // The first address of a line must be issued two cycles before HREF
  // rises; with a two-cycle gap that edge falls in the preceding state.
  localparam bit   VB_SHORT  = (V_BACK == 2);
  localparam bit   HB_SHORT  = (H_BLANK == 2);
  localparam cnt_t VB_PREF   = CNT_W'(V_BACK - 3);
  localparam cnt_t HB_PREF   = CNT_W'(H_BLANK - 3);

  state_t      state;
  state_t      state_next;
  cnt_t        cnt;
  cnt_t        cnt_next;
  cnt_t        line_cnt;
  cnt_t        line_cnt_next;

  logic [14:0] x_next;
  logic [14:0] y_next;
  logic [7:0]  d_next;
  logic [7:0]  hi_byte;
  logic [7:0]  hi_next;
  logic        vsync_next;
  logic        href_next;
  logic        busy_next;
  logic        done_next;

  logic        more_lines;
  logic        pref_first;
  logic        pref_next;
  logic        x_step;
  logic        low_phase;

  // State register with its phase and line counters.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      line_cnt <= '0;
    end else begin
      state    <= state_next;
      cnt      <= cnt_next;
      line_cnt <= line_cnt_next;
    end
  end

  // Next-state sequencing and counter update.
  always_comb begin
    state_next    = state;
    cnt_next      = '0;
    line_cnt_next = line_cnt;

    case (state)
      ST_IDLE: begin
        if (EN) state_next = ST_VSYNC;
      end
      ST_VSYNC: begin
        if (cnt == VS_LAST) state_next = ST_VBACK;
      end
      ST_VBACK: begin
        if (cnt == VB_LAST) state_next = ST_LINE;
      end
      ST_LINE: begin
        if (cnt == LINE_LAST) state_next = ST_HBLANK;
      end
      ST_HBLANK: begin
        if (cnt == HB_LAST) state_next = (line_cnt < LINES) ? ST_LINE : ST_END;
      end
      ST_END: begin
        state_next = EN ? ST_VSYNC : ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase

    if ((state_next != state) || (state == ST_IDLE)) begin
      cnt_next = '0;
    end else begin
      cnt_next = cnt + CNT_W'(1);
    end

    if ((state == ST_LINE) && (state_next == ST_HBLANK)) begin
      line_cnt_next = line_cnt + CNT_W'(1);
    end else if ((state_next == ST_VSYNC) || (state_next == ST_IDLE)) begin
      line_cnt_next = '0;
    end
  end

  // Address generation, byte selection and registered-output next values.
  always_comb begin
    x_next     = RD_X;
    y_next     = RD_Y;
    d_next     = '0;
    hi_next    = hi_byte;
    vsync_next = (state_next == ST_VSYNC);
    href_next  = (state_next == ST_LINE);
    busy_next  = (state_next != ST_IDLE);
    done_next  = (state_next == ST_END);

    // In the two-cycle-blank case the lookahead edge is the last LINE
    // cycle, before line_cnt has counted the current line.
    more_lines = HB_SHORT ? (line_cnt < LINES_M1) : (line_cnt < LINES);

    pref_first = VB_SHORT ? ((state == ST_VSYNC) && (cnt == VS_LAST))
                          : ((state == ST_VBACK) && (cnt == VB_PREF));
    pref_next  = more_lines &&
                 (HB_SHORT ? ((state == ST_LINE) && (cnt == LINE_LAST))
                           : ((state == ST_HBLANK) && (cnt == HB_PREF)));

    // Next column is requested on each edge that loads a low byte.
    x_step = (((state_next == ST_LINE) && (state != ST_LINE)) ||
              ((state == ST_LINE) && cnt[0])) && (RD_X != X_LAST);

    if (pref_first) begin
      x_next = '0;
      y_next = '0;
    end else if (pref_next) begin
      x_next = '0;
      y_next = RD_Y + 15'd1;
    end else if (x_step) begin
      x_next = RD_X + 15'd1;
    end

    if ((state_next == ST_END) || (state_next == ST_IDLE)) begin
      x_next = '0;
      y_next = '0;
    end

    low_phase = ~cnt_next[0];
    if (href_next) begin
      if (low_phase) begin
        d_next  = RD_DATA[7:0];
        hi_next = RD_DATA[15:8];
      end else begin
        d_next  = hi_byte;
      end
    end
  end

  // Output and high-byte holding registers.
  always_ff @(posedge CLK or negedge RES) begin
    if (!RES) begin
      RD_X       <= '0;
      RD_Y       <= '0;
      D          <= '0;
      hi_byte    <= '0;
      VSYNC      <= 1'b0;
      HREF       <= 1'b0;
      BUSY       <= 1'b0;
      FRAME_DONE <= 1'b0;
    end else begin
      RD_X       <= x_next;
      RD_Y       <= y_next;
      D          <= d_next;
      hi_byte    <= hi_next;
      VSYNC      <= vsync_next;
      HREF       <= href_next;
      BUSY       <= busy_next;
      FRAME_DONE <= done_next;
    end
  end

endmodule

// File: tb/tb_pixel_stream_tx.sv
// Directed bench for pixel_stream_tx with a small frame geometry.
module tb_pixel_stream_tx;

  localparam int HA       = 4;
  localparam int VA       = 2;
  localparam int VSL      = 3;
  localparam int VB       = 2;
  localparam int HB       = 2;
  localparam int LINE_LEN = 2 * HA + HB;
  localparam int L0       = VSL + VB;
  localparam int FRAME    = VSL + VB + VA * LINE_LEN + 1;

  logic        CLK = 1'b0;
  logic        RES = 1'b0;
  logic        EN  = 1'b0;
  logic [14:0] RD_X;
  logic [14:0] RD_Y;
  logic [15:0] RD_DATA = '0;
  logic        VSYNC;
  logic        HREF;
  logic [7:0]  D;
  logic        BUSY;
  logic        FRAME_DONE;

  int n_checks = 0;
  int n_fail   = 0;

  pixel_stream_tx #(
    .H_ACTIVE(HA),
    .V_ACTIVE(VA),
    .VS_LEN  (VSL),
    .V_BACK  (VB),
    .H_BLANK (HB)
  ) dut (
    .CLK       (CLK),
    .RES       (RES),
    .EN        (EN),
    .RD_X      (RD_X),
    .RD_Y      (RD_Y),
    .RD_DATA   (RD_DATA),
    .VSYNC     (VSYNC),
    .HREF      (HREF),
    .D         (D),
    .BUSY      (BUSY),
    .FRAME_DONE(FRAME_DONE)
  );

  always #5 CLK = ~CLK;

  // Frame memory contents: a marker word at the origin, {y,x} elsewhere.
  function automatic logic [15:0] mem_word(input logic [14:0] x, input logic [14:0] y);
    if (x == 15'd0 && y == 15'd0) return 16'hA5C3;
    return {y[7:0], x[7:0]};
  endfunction

  // Synchronous memory with one cycle of read latency.
  always @(posedge CLK) RD_DATA <= mem_word(RD_X, RD_Y);

  // Expected outputs for cycle tt of a frame (cycle 0 = first VSYNC cycle).
  function automatic void frame_model(input int tt, output logic vs, output logic hr,
                                      output logic fd, output logic [7:0] d,
                                      output logic [14:0] x, output logic [14:0] y);
    int ls;
    int idx;
    int px;
    logic [15:0] w;
    vs = (tt < VSL);
    fd = (tt == FRAME - 1);
    hr = 1'b0;
    d  = 8'h00;
    x  = 15'd0;
    y  = 15'd0;
    for (int l = 0; l < VA; l++) begin
      ls = L0 + l * LINE_LEN;
      if (tt >= ls - 2) begin
        y  = 15'(l);
        px = (tt < ls) ? 0 : ((tt - ls) / 2 + 1);
        if (px > HA - 1) px = HA - 1;
        x  = 15'(px);
      end
      if (tt >= ls && tt < ls + 2 * HA) begin
        idx = tt - ls;
        hr  = 1'b1;
        w   = mem_word(15'(idx / 2), 15'(l));
        d   = idx[0] ? w[15:8] : w[7:0];
      end
    end
    if (fd) begin
      x = 15'd0;
      y = 15'd0;
    end
  endfunction

  // Reset values, and EN ignored while reset is held.
  task automatic test_reset();
    RES = 1'b0;
    EN  = 1'b0;
    #2;
    n_checks++; if (VSYNC !== 1'b0) begin n_fail++; $display("FAIL reset_vsync got %b expected 0", VSYNC); end
    n_checks++; if (HREF !== 1'b0) begin n_fail++; $display("FAIL reset_href got %b expected 0", HREF); end
    n_checks++; if (D !== 8'h00) begin n_fail++; $display("FAIL reset_d got %h expected 00", D); end
    n_checks++; if (RD_X !== 15'd0) begin n_fail++; $display("FAIL reset_rd_x got %0d expected 0", RD_X); end
    n_checks++; if (RD_Y !== 15'd0) begin n_fail++; $display("FAIL reset_rd_y got %0d expected 0", RD_Y); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b expected 0", BUSY); end
    n_checks++; if (FRAME_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_frame_done got %b expected 0", FRAME_DONE); end
    repeat (2) @(negedge CLK);
    EN = 1'b1;
    @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_hold_busy got %b expected 0", BUSY); end
    n_checks++; if (VSYNC !== 1'b0) begin n_fail++; $display("FAIL reset_hold_vsync got %b expected 0", VSYNC); end
    EN  = 1'b0;
    RES = 1'b1;
    @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL idle_busy got %b expected 0", BUSY); end
  endtask

  // Two back-to-back frames with EN held: full waveform, bytes and addresses.
  task automatic test_frame_timing();
    logic e_vs, e_hr, e_fd;
    logic [7:0] e_d;
    logic [14:0] e_x, e_y;
    int tt;
    EN = 1'b1;
    for (int t = 0; t < 2 * FRAME; t++) begin
      @(negedge CLK);
      tt = t % FRAME;
      frame_model(tt, e_vs, e_hr, e_fd, e_d, e_x, e_y);
      n_checks++; if (VSYNC !== e_vs) begin n_fail++; $display("FAIL frame_vsync t=%0d got %b expected %b", t, VSYNC, e_vs); end
      n_checks++; if (HREF !== e_hr) begin n_fail++; $display("FAIL frame_href t=%0d got %b expected %b", t, HREF, e_hr); end
      n_checks++; if (FRAME_DONE !== e_fd) begin n_fail++; $display("FAIL frame_done t=%0d got %b expected %b", t, FRAME_DONE, e_fd); end
      n_checks++; if (BUSY !== 1'b1) begin n_fail++; $display("FAIL frame_busy t=%0d got %b expected 1", t, BUSY); end
      n_checks++; if (D !== e_d) begin n_fail++; $display("FAIL frame_d t=%0d got %h expected %h", t, D, e_d); end
      n_checks++; if (RD_X !== e_x) begin n_fail++; $display("FAIL frame_rd_x t=%0d got %0d expected %0d", t, RD_X, e_x); end
      n_checks++; if (RD_Y !== e_y) begin n_fail++; $display("FAIL frame_rd_y t=%0d got %0d expected %0d", t, RD_Y, e_y); end
      if (tt == L0) begin
        n_checks++; if (D !== 8'hC3) begin n_fail++; $display("FAIL first_low_byte got %h expected c3", D); end
      end
      if (tt == L0 + 1) begin
        n_checks++; if (D !== 8'hA5) begin n_fail++; $display("FAIL first_high_byte got %h expected a5", D); end
      end
    end
    EN = 1'b0;
    @(negedge CLK);
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL frame_to_idle_busy got %b expected 0", BUSY); end
    n_checks++; if (VSYNC !== 1'b0) begin n_fail++; $display("FAIL frame_to_idle_vsync got %b expected 0", VSYNC); end
  endtask

  // EN dropped during line 0: frame completes, one FRAME_DONE, then idle.
  task automatic test_en_drop();
    logic e_vs, e_hr, e_fd;
    logic [7:0] e_d;
    logic [14:0] e_x, e_y;
    int pulses = 0;
    EN = 1'b1;
    for (int t = 0; t < FRAME + 10; t++) begin
      @(negedge CLK);
      if (t < FRAME) begin
        frame_model(t, e_vs, e_hr, e_fd, e_d, e_x, e_y);
      end else begin
        e_vs = 1'b0; e_hr = 1'b0; e_fd = 1'b0; e_d = 8'h00; e_x = 15'd0; e_y = 15'd0;
      end
      if (FRAME_DONE === 1'b1) pulses++;
      n_checks++; if (BUSY !== (t < FRAME)) begin n_fail++; $display("FAIL endrop_busy t=%0d got %b expected %b", t, BUSY, (t < FRAME)); end
      n_checks++; if (FRAME_DONE !== e_fd) begin n_fail++; $display("FAIL endrop_frame_done t=%0d got %b expected %b", t, FRAME_DONE, e_fd); end
      n_checks++; if (HREF !== e_hr) begin n_fail++; $display("FAIL endrop_href t=%0d got %b expected %b", t, HREF, e_hr); end
      n_checks++; if (VSYNC !== e_vs) begin n_fail++; $display("FAIL endrop_vsync t=%0d got %b expected %b", t, VSYNC, e_vs); end
      if (t == L0 + 1) EN = 1'b0;
    end
    n_checks++; if (pulses != 1) begin n_fail++; $display("FAIL endrop_pulse_count got %0d expected 1", pulses); end
  endtask

  // Reset mid-line: outputs clear at once, no FRAME_DONE, clean restart.
  task automatic test_reset_midline();
    logic e_vs, e_hr, e_fd;
    logic [7:0] e_d;
    logic [14:0] e_x, e_y;
    int waited;
    EN = 1'b1;
    for (int t = 0; t <= L0 + 2; t++) @(negedge CLK);
    n_checks++; if (HREF !== 1'b1) begin n_fail++; $display("FAIL midline_href_before got %b expected 1", HREF); end
    n_checks++; if (D !== 8'h01) begin n_fail++; $display("FAIL midline_d_before got %h expected 01", D); end
    #2;
    RES = 1'b0;
    #1;
    n_checks++; if (HREF !== 1'b0) begin n_fail++; $display("FAIL midline_href got %b expected 0", HREF); end
    n_checks++; if (D !== 8'h00) begin n_fail++; $display("FAIL midline_d got %h expected 00", D); end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL midline_busy got %b expected 0", BUSY); end
    n_checks++; if (RD_X !== 15'd0) begin n_fail++; $display("FAIL midline_rd_x got %0d expected 0", RD_X); end
    n_checks++; if (RD_Y !== 15'd0) begin n_fail++; $display("FAIL midline_rd_y got %0d expected 0", RD_Y); end
    for (int t = 0; t < 3; t++) begin
      @(negedge CLK);
      n_checks++; if (FRAME_DONE !== 1'b0) begin n_fail++; $display("FAIL midline_no_done t=%0d got %b expected 0", t, FRAME_DONE); end
    end
    RES = 1'b1;
    for (int t = 0; t < L0 + 2 * HA; t++) begin
      @(negedge CLK);
      frame_model(t, e_vs, e_hr, e_fd, e_d, e_x, e_y);
      n_checks++; if (VSYNC !== e_vs) begin n_fail++; $display("FAIL restart_vsync t=%0d got %b expected %b", t, VSYNC, e_vs); end
      n_checks++; if (HREF !== e_hr) begin n_fail++; $display("FAIL restart_href t=%0d got %b expected %b", t, HREF, e_hr); end
      n_checks++; if (D !== e_d) begin n_fail++; $display("FAIL restart_d t=%0d got %h expected %h", t, D, e_d); end
      n_checks++; if (RD_X !== e_x) begin n_fail++; $display("FAIL restart_rd_x t=%0d got %0d expected %0d", t, RD_X, e_x); end
      n_checks++; if (RD_Y !== e_y) begin n_fail++; $display("FAIL restart_rd_y t=%0d got %0d expected %0d", t, RD_Y, e_y); end
    end
    EN = 1'b0;
    waited = 0;
    while (BUSY !== 1'b0 && waited < 4 * FRAME) begin
      @(negedge CLK);
      waited++;
    end
    n_checks++; if (BUSY !== 1'b0) begin n_fail++; $display("FAIL restart_idle_timeout got busy=%b expected 0", BUSY); end
  endtask

  initial begin
    test_reset();
    test_frame_timing();
    test_en_drop();
    test_reset_midline();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end

endmodule
